// File: rtl/fifo_read_arbiter.sv
// Read-domain controller for the dual-clock FIFO: owns the read pointer, generates
// the registered empty flag, and shares the read port between consumers round-robin.
module fifo_read_arbiter #(
    parameter int ADDRESS_SIZE = 4,
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 4,
    localparam int OWNER_W     = $clog2(NUM_REQ),
    localparam int CNT_W       = $clog2(MAX_BURST + 1)
) (
    input  logic                    rclk,
    input  logic                    rrst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [ADDRESS_SIZE:0]   rq2_write_ptr,
    output logic [ADDRESS_SIZE:0]   read_ptr,
    output logic [ADDRESS_SIZE-1:0] raddr,
    output logic                    rinc,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [OWNER_W-1:0]      owner,
    output logic                    busy,
    output logic                    rempty
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                r_state;
    logic [ADDRESS_SIZE:0] r_rbin;
    logic [ADDRESS_SIZE:0] r_read_ptr;
    logic                  r_rempty;
    logic [OWNER_W-1:0]    r_owner;
    logic [OWNER_W-1:0]    r_prio;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_rinc;
    logic [ADDRESS_SIZE:0] w_rbinnext;
    logic [ADDRESS_SIZE:0] w_rgraynext;
    logic [OWNER_W-1:0]    w_pick;
    logic                  w_pick_vld;
    logic [OWNER_W-1:0]    w_owner_inc;

    // First asserted request at or above the round-robin pointer, wrapping around.
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_pick_vld && req[(32'(r_prio) + i) % NUM_REQ]) begin
                w_pick     = OWNER_W'((32'(r_prio) + i) % NUM_REQ);
                w_pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_rinc      = (r_state == BURST) && req[r_owner] && !r_rempty;
        w_rbinnext  = r_rbin + (ADDRESS_SIZE + 1)'(w_rinc);
        w_rgraynext = (w_rbinnext >> 1) ^ w_rbinnext;
        w_owner_inc = (32'(r_owner) == NUM_REQ - 1) ? '0 : r_owner + 1'b1;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_rbin     <= '0;
            r_read_ptr <= '0;
            r_rempty   <= 1'b1;
            r_state    <= IDLE;
            r_owner    <= '0;
            r_prio     <= '0;
            r_cnt      <= '0;
        end else begin
            r_rbin     <= w_rbinnext;
            r_read_ptr <= w_rgraynext;
            // Full-width compare: the MSB separates laps, so a full FIFO never reads as empty.
            r_rempty   <= (w_rgraynext == rq2_write_ptr);
            case (r_state)
                IDLE: begin
                    if (w_pick_vld && !r_rempty) begin
                        r_owner <= w_pick;
                        r_cnt   <= '0;
                        r_state <= BURST;
                    end
                end
                BURST: begin
                    if (w_rinc) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(MAX_BURST - 1)) begin
                            r_state <= IDLE;
                            r_prio  <= w_owner_inc;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_prio  <= w_owner_inc;
                    end
                end
            endcase
        end
    end

    assign read_ptr = r_read_ptr;
    assign raddr    = r_rbin[ADDRESS_SIZE-1:0];
    assign rinc     = w_rinc;
    assign gnt      = w_rinc ? (NUM_REQ'(1) << r_owner) : '0;
    assign owner    = r_owner;
    assign busy     = (r_state == BURST);
    assign rempty   = r_rempty;

endmodule

// File: doc/fifo_read_arbiter.md
# fifo_read_arbiter

Read-domain controller for the dual-clock FIFO. It owns the read pointer and shares the single FIFO read port between `NUM_REQ` consumers with round-robin, bounded-burst arbitration. It also generates the registered empty flag from the synchronized Gray write pointer, and drives the memory read address and the Gray read pointer that goes back to the write-side synchronizer.

## Interface
- `ADDRESS_SIZE`, default 4: FIFO depth is 2^ADDRESS_SIZE; pointers are ADDRESS_SIZE+1 bits wide.
- `NUM_REQ`, default 4: number of consumers; must be ≥2.
- `MAX_BURST`, default 4: maximum pops per grant tenure; must be ≥1.
- `rclk`: input, 1 bit. Read clock; the only clock in the block.
- `rrst`: input, 1 bit. Synchronous, active-high reset on `rclk`.
- `req`: input, NUM_REQ bits. Per-consumer request; level-sensitive.
- `rq2_write_ptr`: input, ADDRESS_SIZE+1 bits. Gray write pointer, already two-flop synchronized into `rclk`.
- `read_ptr`: output, ADDRESS_SIZE+1 bits. Registered Gray read pointer, sent to the write domain.
- `raddr`: output, ADDRESS_SIZE bits. Binary read address to the FIFO memory (combinational-read memory).
- `rinc`: output, 1 bit. Pop strobe; high exactly on cycles where one word is consumed.
- `gnt`: output, NUM_REQ bits. One-hot; `gnt[i]` is high on a pop cycle for consumer i, and that consumer samples `rdata` in that cycle.
- `owner`: output, $clog2(NUM_REQ) bits. Current or last burst owner.
- `busy`: output, 1 bit. High while the FSM is in BURST.
- `rempty`: output, 1 bit. Registered empty flag.

## Operation
- State held: binary pointer `rbin`, Gray `read_ptr`, `rempty`, FSM state {IDLE, BURST}, `owner`, round-robin pointer `prio`, burst counter `cnt` ($clog2(MAX_BURST+1) bits).
- `raddr = rbin[ADDRESS_SIZE-1:0]`.
- `rbinnext = rbin + rinc`, modulo 2^(ADDRESS_SIZE+1). `rgraynext = (rbinnext>>1) ^ rbinnext`.
- On every `rclk`: `rbin <= rbinnext`, `read_ptr <= rgraynext`, `rempty <= (rgraynext == rq2_write_ptr)`. This is a full-width compare, so the MSB distinguishes wrap laps.
- `rinc = (state==BURST) & req[owner] & ~rempty`. `gnt = rinc ? onehot(owner) : 0`. `gnt` depends combinationally on `req`.
- IDLE: if `|req & ~rempty`, select the first asserted `req` searching upward from `prio` with wrap. Load `owner` with it, clear `cnt`, go to BURST. No pop happens in IDLE. Otherwise stay in IDLE.
- BURST with `rinc`: `cnt <= cnt+1`. If `cnt == MAX_BURST-1`, go to IDLE and set `prio <= owner+1` (mod NUM_REQ).
- BURST with no `rinc` (owner dropped `req`, or `rempty`): go to IDLE, set `prio <= owner+1`, no pop.
- A request from a non-owner is never served during another consumer's burst.
- Reset: `rbin`=0, `read_ptr`=0, `rempty`=1, state IDLE, `owner`=0, `prio`=0, `cnt`=0. Consequently `rinc`=0, `gnt`=0, `busy`=0, `raddr`=0.
- Reset asserted mid-burst: the next edge returns every register to its reset value. The in-flight cycle's pop does not occur because reset has priority.

## Timing
- Write-to-visibility: a write advances `rq2_write_ptr` 2 `rclk` edges after `write_ptr` changes. `rempty` falls 1 edge later. The first pop occurs 2 edges after that (IDLE decision edge, then the BURST pop cycle).
- Within a burst, pops run back-to-back at one per cycle, up to MAX_BURST.
- Every burst end costs exactly one IDLE cycle before the next grant.
- Going empty after the last word: `rempty` rises on the same edge that registers the final pop. The next BURST cycle sees `rempty`=1 and exits with no pop.
- Pointer wrap: after 2^(ADDRESS_SIZE+1) pops, `rbin` and `read_ptr` return to 0 with no special handling.

## Test plan
- Reset: assert `rrst` for 2 cycles with `req`=all ones → `rempty`=1, `read_ptr`=0, `gnt`=0, `rinc`=0, `busy`=0, `owner`=0.
- Single consumer (defaults): `rq2_write_ptr` = Gray(3), `req`=0001 held → one IDLE cycle, then `gnt`=0001 for 3 consecutive cycles. `read_ptr` steps 1, 3, 2, then `rempty`=1 and the FSM returns to IDLE.
- Two consumers, FIFO holding 10 words, `req`=0011 held → bursts of 4 (owner 0), 4 (owner 1), 2 (owner 0). Each burst is separated by one IDLE cycle; 10 `rinc` pulses in total.
- Owner drops `req` after 2 pops with `req[2]` pending → BURST exits with no pop. Owner becomes 2 on the next decision, and `prio` skips the old owner.
- Wrap: stream 40 words through the FIFO → `read_ptr` wraps past Gray(31) to 0. `rempty` asserts only when the full 5-bit pointers match, never on the index bits alone.
- Reset mid-burst: assert `rrst` on the second pop cycle of a burst → no pop on that edge, and every output is at its reset value on the following cycle.
